// File: rtl/exception_addr_ctrl.sv
// Exception sequencer: steals the memory-address mux to fetch the handler byte, then writes PC/EPC.
// Busy for MEM_LAT+1 cycles after the event edge; the control unit stalls on exc_busy, no other backpressure.
module exception_addr_ctrl #(
   parameter int MEM_LAT    = 1,
   parameter int EPC_OFFSET = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  iord_ctrl,
   input  logic        mem_wr_ctrl,
   input  logic        exc_opcode,
   input  logic        exc_overflow,
   input  logic        exc_div0,
   input  logic [31:0] pc_in,
   input  logic [31:0] mem_data_in,
   output logic [2:0]  IorD,
   output logic        mem_wr,
   output logic [31:0] pc_out,
   output logic        pc_wr,
   output logic [31:0] epc_out,
   output logic        epc_wr,
   output logic        exc_busy,
   output logic [1:0]  exc_cause
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_UPDATE = 2'd2;

   localparam logic [1:0] CAUSE_OPCODE   = 2'b01;
   localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
   localparam logic [1:0] CAUSE_DIV0     = 2'b11;

   localparam logic [2:0]  CNT_INIT = 3'(MEM_LAT - 1);
   localparam logic [31:0] EPC_OFF  = 32'(EPC_OFFSET);

   logic [1:0]  r_state;
   logic [2:0]  r_cnt;
   logic [1:0]  r_cause;
   logic [31:0] r_epc;
   logic [31:0] r_handler;

   logic        w_any_exc;
   logic [1:0]  w_cause_nxt;
   logic [2:0]  w_vector;
   logic        w_idle;
   logic        w_unused_data;

   assign w_any_exc     = exc_opcode | exc_overflow | exc_div0;
   assign w_idle        = (r_state == S_IDLE);
   // Only the low byte of the vector word carries the handler address.
   assign w_unused_data = ^mem_data_in[31:8];

   always_comb begin
      w_cause_nxt = CAUSE_DIV0;
      if (exc_opcode) begin
         w_cause_nxt = CAUSE_OPCODE;
      end else if (exc_overflow) begin
         w_cause_nxt = CAUSE_OVERFLOW;
      end
   end

   always_comb begin
      w_vector = 3'b000;
      case (r_cause)
         CAUSE_OPCODE:   w_vector = 3'b011;
         CAUSE_OVERFLOW: w_vector = 3'b100;
         CAUSE_DIV0:     w_vector = 3'b101;
         default:        w_vector = 3'b000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 3'd0;
         r_cause   <= 2'b00;
         r_epc     <= 32'd0;
         r_handler <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_exc) begin
                  r_cause <= w_cause_nxt;
                  r_epc   <= pc_in - EPC_OFF;
                  r_cnt   <= CNT_INIT;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               // Memory data is only trusted on the last cycle of the latency window.
               if (r_cnt == 3'd0) begin
                  r_handler <= {24'd0, mem_data_in[7:0]};
                  r_state   <= S_UPDATE;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            S_UPDATE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Vector select and write gating are state-decoded, so the mux never glitches back mid-sequence.
   assign IorD      = w_idle ? iord_ctrl : w_vector;
   assign mem_wr    = w_idle & mem_wr_ctrl;
   assign exc_busy  = ~w_idle;
   assign pc_wr     = (r_state == S_UPDATE);
   assign epc_wr    = (r_state == S_UPDATE);
   assign pc_out    = r_handler;
   assign epc_out   = r_epc;
   assign exc_cause = r_cause;

endmodule

// File: tb/tb_exception_addr_ctrl.sv
// Bench: two instances (MEM_LAT=1 and 3) share stimulus; each is checked against a sequence-position model.
module tb_exception_addr_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  iord_ctrl;
   logic        mem_wr_ctrl;
   logic        exc_opcode, exc_overflow, exc_div0;
   logic [31:0] pc_in, mem_data_in;

   logic [2:0]  iord      [2];
   logic        mem_wr    [2];
   logic [31:0] pc_out    [2];
   logic        pc_wr     [2];
   logic [31:0] epc_out   [2];
   logic        epc_wr    [2];
   logic        busy      [2];
   logic [1:0]  cause     [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   exception_addr_ctrl #(.MEM_LAT(1), .EPC_OFFSET(4)) u_lat1 (
      .clk(clk), .reset(reset), .iord_ctrl(iord_ctrl), .mem_wr_ctrl(mem_wr_ctrl),
      .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
      .pc_in(pc_in), .mem_data_in(mem_data_in),
      .IorD(iord[0]), .mem_wr(mem_wr[0]), .pc_out(pc_out[0]), .pc_wr(pc_wr[0]),
      .epc_out(epc_out[0]), .epc_wr(epc_wr[0]), .exc_busy(busy[0]), .exc_cause(cause[0]));

   exception_addr_ctrl #(.MEM_LAT(3), .EPC_OFFSET(4)) u_lat3 (
      .clk(clk), .reset(reset), .iord_ctrl(iord_ctrl), .mem_wr_ctrl(mem_wr_ctrl),
      .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
      .pc_in(pc_in), .mem_data_in(mem_data_in),
      .IorD(iord[1]), .mem_wr(mem_wr[1]), .pc_out(pc_out[1]), .pc_wr(pc_wr[1]),
      .epc_out(epc_out[1]), .epc_wr(epc_wr[1]), .exc_busy(busy[1]), .exc_cause(cause[1]));

   function automatic int lat(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got 0x%08h want 0x%08h at %0t", nm, inst, act, exp, $time);
      end
   endtask

   // Model: pos = cycles since the accepted event (0 = idle, 1..LAT fetch, LAT+1 update).
   int          pos [2];
   logic [1:0]  m_cause [2];
   logic [31:0] m_epc [2];
   logic [31:0] m_pc [2];
   bit          started = 0;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            pos[i] = 0; m_cause[i] = 2'd0; m_epc[i] = 32'd0; m_pc[i] = 32'd0;
         end else if (pos[i] == 0) begin
            if (exc_opcode || exc_overflow || exc_div0) begin
               m_cause[i] = exc_opcode ? 2'd1 : (exc_overflow ? 2'd2 : 2'd3);
               m_epc[i]   = pc_in - 32'd4;
               pos[i]     = 1;
            end
         end else if (pos[i] <= lat(i)) begin
            if (pos[i] == lat(i)) m_pc[i] = {24'd0, mem_data_in[7:0]};
            pos[i] = pos[i] + 1;
         end else begin
            pos[i] = 0;
         end
      end
      if (reset) started = 1;
   end

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            chk("iord", i, 32'(iord[i]), (pos[i] == 0) ? 32'(iord_ctrl) : 32'(m_cause[i]) + 32'd2);
            chk("mem_wr", i, 32'(mem_wr[i]), (pos[i] == 0) ? 32'(mem_wr_ctrl) : 32'd0);
            chk("busy", i, 32'(busy[i]), 32'(pos[i] != 0));
            chk("pc_wr", i, 32'(pc_wr[i]), 32'(pos[i] == lat(i) + 1));
            chk("epc_wr", i, 32'(epc_wr[i]), 32'(pos[i] == lat(i) + 1));
            chk("cause", i, 32'(cause[i]), 32'(m_cause[i]));
            chk("pc_out", i, pc_out[i], m_pc[i]);
            if (pos[i] == 0 || pos[i] == lat(i) + 1)
               chk("epc_out", i, epc_out[i], m_epc[i]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   int busy_cnt;
   logic [31:0] mem_seq [6];

   initial begin
      reset = 1'b1; iord_ctrl = 3'd0; mem_wr_ctrl = 1'b0;
      exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
      pc_in = 32'd0; mem_data_in = 32'd0;
      tick(); tick();
      chk("rst_busy", 0, 32'(busy[0]), 32'd0);
      chk("rst_cause", 1, 32'(cause[1]), 32'd0);
      chk("rst_pc", 0, pc_out[0], 32'd0);
      chk("rst_epc", 1, epc_out[1], 32'd0);
      reset = 1'b0;
      tick();

      // Overflow, single-cycle latency
      pc_in = 32'h40; exc_overflow = 1'b1; mem_data_in = 32'h80;
      tick();
      exc_overflow = 1'b0;
      chk("t1_iord_f", 0, 32'(iord[0]), 32'd4);
      chk("t1_cause", 0, 32'(cause[0]), 32'd2);
      tick();
      chk("t1_iord_u", 0, 32'(iord[0]), 32'd4);
      chk("t1_pc_wr", 0, 32'(pc_wr[0]), 32'd1);
      chk("t1_epc_wr", 0, 32'(epc_wr[0]), 32'd1);
      chk("t1_pc", 0, pc_out[0], 32'h80);
      chk("t1_epc", 0, epc_out[0], 32'h3C);
      tick();
      chk("t1_busy_end", 0, 32'(busy[0]), 32'd0);
      idle(6);

      // Priority
      exc_opcode = 1'b1; exc_overflow = 1'b1; exc_div0 = 1'b1; mem_data_in = 32'hFFFF_FF7C;
      tick();
      exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
      chk("t2_iord", 0, 32'(iord[0]), 32'd3);
      chk("t2_cause", 0, 32'(cause[0]), 32'd1);
      tick();
      chk("t2_pc", 0, pc_out[0], 32'h7C);
      idle(6);

      // Latency 3: only last FETCH cycle's data is captured
      mem_seq[0] = 32'h22; mem_seq[1] = 32'h33; mem_seq[2] = 32'h44;
      mem_seq[3] = 32'h55; mem_seq[4] = 32'h66; mem_seq[5] = 32'h77;
      exc_div0 = 1'b1; mem_data_in = 32'h11;
      tick();
      exc_div0 = 1'b0;
      busy_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         if (busy[1]) begin
            busy_cnt++;
            chk("t3_iord", 1, 32'(iord[1]), 32'd5);
         end
         if (k == 3) chk("t3_pc", 1, pc_out[1], 32'h33);
         tick();
         mem_data_in = mem_seq[k];
      end
      chk("t3_busy_cycles", 1, 32'(busy_cnt), 32'd4);
      idle(4);

      // Pass-through sweep, then forced mem_wr=0 during FETCH
      for (int v = 0; v < 8; v++) begin
         tick();
         iord_ctrl = 3'(v); mem_wr_ctrl = 1'b1;
         #1;
         chk("t4_iord", 0, 32'(iord[0]), 32'(v));
         chk("t4_mem_wr", 0, 32'(mem_wr[0]), 32'd1);
      end
      tick();
      exc_opcode = 1'b1;
      tick();
      exc_opcode = 1'b0;
      chk("t4_mem_wr_fetch", 0, 32'(mem_wr[0]), 32'd0);
      chk("t4_mem_wr_fetch", 1, 32'(mem_wr[1]), 32'd0);
      idle(6);

      // Reset in second FETCH cycle of the latency-3 instance
      pc_in = 32'h1234; exc_div0 = 1'b1;
      tick();
      exc_div0 = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_busy", 1, 32'(busy[1]), 32'd0);
      chk("t5_cause", 1, 32'(cause[1]), 32'd0);
      chk("t5_pc", 1, pc_out[1], 32'd0);
      chk("t5_epc", 1, epc_out[1], 32'd0);
      chk("t5_iord", 1, 32'(iord[1]), 32'd7);
      for (int k = 0; k < 5; k++) begin
         chk("t5_no_pc_wr", 1, 32'(pc_wr[1]), 32'd0);
         chk("t5_no_epc_wr", 1, 32'(epc_wr[1]), 32'd0);
         tick();
      end

      // Event during FETCH is ignored; EPC wraps
      exc_opcode = 1'b1;
      tick();
      exc_opcode = 1'b0; exc_overflow = 1'b1;
      chk("t6_cause_f", 0, 32'(cause[0]), 32'd1);
      tick();
      exc_overflow = 1'b0;
      chk("t6_cause_u", 0, 32'(cause[0]), 32'd1);
      idle(6);
      pc_in = 32'h2; exc_overflow = 1'b1;
      tick();
      exc_overflow = 1'b0;
      tick();
      chk("t6_epc_wrap", 0, epc_out[0], 32'hFFFF_FFFE);
      idle(6);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset        = ($urandom_range(0, 63) == 0);
         exc_opcode   = ($urandom_range(0, 5) == 0);
         exc_overflow = ($urandom_range(0, 5) == 0);
         exc_div0     = ($urandom_range(0, 5) == 0);
         iord_ctrl    = 3'($urandom_range(0, 7));
         mem_wr_ctrl  = 1'($urandom_range(0, 1));
         pc_in        = $urandom;
         mem_data_in  = $urandom;
         tick();
      end
      reset = 1'b0; exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
      idle(8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
